// File: rtl/cache_preload_if.sv
// Preload command channel plus the borrowed L1 array write ports.
// The slave side is the preloader; the master side drives commands and grants.
interface cache_preload_if #(
  parameter int WAYS   = 4,
  parameter int IDX_W  = 13,
  parameter int TAG_W  = 14,
  parameter int LINE_W = 256,
  parameter int LRU_W  = 3
);
  logic              pl_valid;
  logic              pl_ready;
  logic [1:0]        pl_cmd;
  logic [WAYS-1:0]   pl_way;
  logic [IDX_W-1:0]  pl_idx;
  logic [TAG_W-1:0]  pl_tag;
  logic [LINE_W-1:0] pl_data;
  logic              pl_dirty;
  logic [LRU_W-1:0]  pl_lru;
  logic              arb_req;
  logic              arb_gnt;
  logic [WAYS-1:0]   tag_we;
  logic [WAYS-1:0]   data_we;
  logic [IDX_W-1:0]  arr_idx;
  logic [TAG_W-1:0]  tag_d;
  logic [LINE_W-1:0] data_d;
  logic              vb_we;
  logic [WAYS-1:0]   vb_mask;
  logic              vb_val;
  logic              mod_val;
  logic              lru_we;
  logic [LRU_W-1:0]  lru_d;
  logic              done;
  logic              err;

  modport slave (
    input  pl_valid, pl_cmd, pl_way, pl_idx, pl_tag, pl_data, pl_dirty, pl_lru, arb_gnt,
    output pl_ready, arb_req, tag_we, data_we, arr_idx, tag_d, data_d,
           vb_we, vb_mask, vb_val, mod_val, lru_we, lru_d, done, err
  );

  modport master (
    output pl_valid, pl_cmd, pl_way, pl_idx, pl_tag, pl_data, pl_dirty, pl_lru, arb_gnt,
    input  pl_ready, arb_req, tag_we, data_we, arr_idx, tag_d, data_d,
           vb_we, vb_mask, vb_val, mod_val, lru_we, lru_d, done, err
  );
endinterface

// File: rtl/cache_preload.sv
// Backdoor writer for the 4-way L1 state arrays: line installs, LRU writes
// and a full-index clear sweep, using array ports borrowed via req/gnt.
module cache_preload #(
  parameter int WAYS   = 4,
  parameter int IDX_W  = 13,
  parameter int TAG_W  = 14,
  parameter int LINE_W = 256,
  parameter int LRU_W  = 3
) (
  input  logic           clk,
  input  logic           reset,
  cache_preload_if.slave pl
);
  localparam logic [1:0] CMD_LRU   = 2'd1;
  localparam logic [1:0] CMD_CLEAR = 2'd2;
  localparam logic [1:0] CMD_ILL   = 2'd3;

  typedef enum logic [2:0] {IDLE, REQ, WRITE, SWEEP, DONE} state_e;

  typedef struct packed {
    logic [1:0]        cmd;
    logic [WAYS-1:0]   way;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
    logic              dirty;
    logic [LRU_W-1:0]  lru;
  } cmd_t;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             way_onehot;

  assign way_onehot = $onehot(cmd_q.way);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pl.pl_ready = 1'b0;
    pl.arb_req  = 1'b0;
    pl.tag_we   = '0;
    pl.data_we  = '0;
    pl.arr_idx  = '0;
    pl.tag_d    = '0;
    pl.data_d   = '0;
    pl.vb_we    = 1'b0;
    pl.vb_mask  = '0;
    pl.vb_val   = 1'b0;
    pl.mod_val  = 1'b0;
    pl.lru_we   = 1'b0;
    pl.lru_d    = '0;
    pl.done     = 1'b0;
    pl.err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        pl.pl_ready = 1'b1;
        if (pl.pl_valid) begin
          cmd_d.cmd   = pl.pl_cmd;
          cmd_d.way   = pl.pl_way;
          cmd_d.idx   = pl.pl_idx;
          cmd_d.tag   = pl.pl_tag;
          cmd_d.data  = pl.pl_data;
          cmd_d.dirty = pl.pl_dirty;
          cmd_d.lru   = pl.pl_lru;
          // Illegal commands never touch the arbiter.
          err_d   = (pl.pl_cmd == CMD_ILL);
          state_d = (pl.pl_cmd == CMD_ILL) ? DONE : REQ;
        end
      end
      REQ: begin
        pl.arb_req = 1'b1;
        if (pl.arb_gnt) begin
          cnt_d   = '0;
          state_d = (cmd_q.cmd == CMD_CLEAR) ? SWEEP : WRITE;
        end
      end
      WRITE: begin
        pl.arb_req = 1'b1;
        // A lost grant keeps us here so the same write is replayed.
        if (pl.arb_gnt) begin
          state_d = DONE;
          if (cmd_q.cmd == CMD_LRU) begin
            pl.lru_we  = 1'b1;
            pl.lru_d   = cmd_q.lru;
            pl.arr_idx = cmd_q.idx;
          end else if (way_onehot) begin
            pl.tag_we  = cmd_q.way;
            pl.data_we = cmd_q.way;
            pl.vb_we   = 1'b1;
            pl.vb_mask = cmd_q.way;
            pl.vb_val  = 1'b1;
            pl.mod_val = cmd_q.dirty;
            pl.arr_idx = cmd_q.idx;
            pl.tag_d   = cmd_q.tag;
            pl.data_d  = cmd_q.data;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SWEEP: begin
        pl.arb_req = 1'b1;
        if (pl.arb_gnt) begin
          pl.vb_we   = 1'b1;
          pl.vb_mask = '1;
          pl.lru_we  = 1'b1;
          pl.arr_idx = cnt_q;
          cnt_d      = cnt_q + 1'b1;
          if (&cnt_q) state_d = DONE;
        end
      end
      DONE: begin
        pl.done = 1'b1;
        pl.err  = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_preload.sv
// Randomized and directed bench for cache_preload against a transaction-level
// model: each command maps to the ordered list of array writes it must produce.
module tb_cache_preload;
  localparam int WAYS = 4, IDX_W = 3, TAG_W = 14, LINE_W = 256, LRU_W = 3;
  localparam int NSET = 1 << IDX_W;

  typedef struct packed {
    logic [WAYS-1:0]   tag_we;
    logic [WAYS-1:0]   data_we;
    logic              vb_we;
    logic [WAYS-1:0]   vb_mask;
    logic              vb_val;
    logic              mod_val;
    logic              lru_we;
    logic [LRU_W-1:0]  lru_d;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag_d;
    logic [LINE_W-1:0] data_d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cache_preload_if #(.WAYS(WAYS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .LRU_W(LRU_W)) bus ();
  cache_preload #(.WAYS(WAYS), .IDX_W(IDX_W), .TAG_W(TAG_W), .LINE_W(LINE_W), .LRU_W(LRU_W)) dut (
    .clk(clk), .reset(reset), .pl(bus)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: log every array write and running event totals.
  wr_t obs[$];
  int  obs_cyc[$];
  int  done_total = 0, done_cyc = 0, req_total = 0, busy_total = 0, gate_bad = 0, zero_bad = 0;
  logic done_err = 1'b0;
  always @(negedge clk) begin
    if (|bus.tag_we || |bus.data_we || bus.vb_we || bus.lru_we) begin
      obs.push_back({bus.tag_we, bus.data_we, bus.vb_we, bus.vb_mask, bus.vb_val, bus.mod_val,
                     bus.lru_we, bus.lru_d, bus.arr_idx, bus.tag_d, bus.data_d});
      obs_cyc.push_back(cyc);
      if (!(bus.arb_req && bus.arb_gnt)) gate_bad <= gate_bad + 1;
    end
    if ((bus.tag_we == '0 && bus.tag_d != '0) || (bus.data_we == '0 && bus.data_d != '0) ||
        (!bus.lru_we && bus.lru_d != '0) || (bus.err && !bus.done))
      zero_bad <= zero_bad + 1;
    if (bus.arb_req) req_total <= req_total + 1;
    if (!bus.pl_ready) busy_total <= busy_total + 1;
    if (bus.done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
      done_err   <= bus.err;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic gnt_rand = 1'b0;
  int   drop_lo = -1, drop_hi = -1;

  task automatic step();
    @(posedge clk);
    #1;
    if (gnt_rand) bus.arb_gnt = ($urandom_range(0, 3) != 0);
    else          bus.arb_gnt = !(cyc >= drop_lo && cyc < drop_hi);
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] d;
    for (int i = 0; i < LINE_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic run(input logic [1:0] cmd, input logic [WAYS-1:0] way, input logic [IDX_W-1:0] idx,
                     input logic [TAG_W-1:0] tag, input logic [LINE_W-1:0] data, input logic dirty,
                     input logic [LRU_W-1:0] lru, input int drop_off, input int drop_len,
                     input int exp_done_off, input string nm);
    wr_t  exp_q[$];
    int   t, d0, r0, b0, base, nobs;
    logic exp_err;
    exp_err = (cmd == 2'd3) || (cmd == 2'd0 && $countones(way) != 1);
    case (cmd)
      2'd0: if ($countones(way) == 1)
              exp_q.push_back({way, way, 1'b1, way, 1'b1, dirty, 1'b0, {LRU_W{1'b0}}, idx, tag, data});
      2'd1: exp_q.push_back({{WAYS{1'b0}}, {WAYS{1'b0}}, 1'b0, {WAYS{1'b0}}, 1'b0, 1'b0, 1'b1, lru, idx,
                             {TAG_W{1'b0}}, {LINE_W{1'b0}}});
      2'd2: for (int i = 0; i < NSET; i++)
              exp_q.push_back({{WAYS{1'b0}}, {WAYS{1'b0}}, 1'b1, {WAYS{1'b1}}, 1'b0, 1'b0, 1'b1,
                               {LRU_W{1'b0}}, IDX_W'(i), {TAG_W{1'b0}}, {LINE_W{1'b0}}});
      default: ;
    endcase
    for (int w = 0; w < 200 && !bus.pl_ready; w++) step();
    chk({nm, ".ready"}, bus.pl_ready, 1'b1);
    bus.pl_cmd = cmd; bus.pl_way = way; bus.pl_idx = idx; bus.pl_tag = tag;
    bus.pl_data = data; bus.pl_dirty = dirty; bus.pl_lru = lru; bus.pl_valid = 1'b1;
    t = cyc; d0 = done_total; r0 = req_total; b0 = busy_total; base = obs.size();
    if (drop_len > 0) begin drop_lo = t + drop_off; drop_hi = t + drop_off + drop_len; end
    step();
    // Scramble inputs after acceptance; the command must already be captured.
    bus.pl_valid = 1'b0; bus.pl_cmd = 2'($urandom); bus.pl_way = WAYS'($urandom);
    bus.pl_idx = IDX_W'($urandom); bus.pl_tag = TAG_W'($urandom); bus.pl_data = rnd_line();
    bus.pl_dirty = 1'($urandom); bus.pl_lru = LRU_W'($urandom);
    for (int w = 0; w < 400 && done_total == d0; w++) step();
    chk({nm, ".done"}, done_total - d0, 1);
    chk({nm, ".err"}, done_err, exp_err);
    if (exp_done_off >= 0) chk({nm, ".lat"}, done_cyc - t, exp_done_off);
    nobs = obs.size() - base;
    chk({nm, ".nwr"}, nobs, exp_q.size());
    for (int k = 0; k < nobs && k < exp_q.size(); k++) chk({nm, ".wr"}, obs[base + k], exp_q[k]);
    if (nobs > 0) begin
      chk({nm, ".lastwr"}, done_cyc - obs_cyc[base + nobs - 1], 1);
      if (exp_done_off >= 0 && drop_len == 0) chk({nm, ".firstwr"}, obs_cyc[base] - t, 2);
    end
    step();
    chk({nm, ".req"}, req_total - r0, (cmd == 2'd3) ? 0 : done_cyc - t - 1);
    chk({nm, ".busy"}, busy_total - b0, done_cyc - t);
    chk({nm, ".gate"}, gate_bad, 0);
    chk({nm, ".zero"}, zero_bad, 0);
    drop_lo = -1; drop_hi = -1;
  endtask

  initial begin
    logic [LINE_W-1:0] dd;
    int t, d0;
    bus.pl_valid = 1'b0; bus.pl_cmd = '0; bus.pl_way = '0; bus.pl_idx = '0; bus.pl_tag = '0;
    bus.pl_data = '0; bus.pl_dirty = 1'b0; bus.pl_lru = '0; bus.arb_gnt = 1'b1;
    repeat (3) step();
    chk("rst.ready", bus.pl_ready, 1'b1);
    chk("rst.outs", {bus.arb_req, bus.done, bus.err, bus.tag_we, bus.data_we, bus.vb_we, bus.lru_we,
                     bus.arr_idx, bus.lru_d}, '0);
    reset = 1'b0;
    step();

    dd = rnd_line(); dd[15:0] = 16'hDEAD;
    run(2'd0, 4'b0100, 3'd5, 14'h1A3, dd, 1'b1, 3'd0, 0, 0, 3, "wline");
    run(2'd1, 4'b0000, 3'd7, 14'h0, '0, 1'b0, 3'b101, 1, 4, 7, "lru_dly");
    run(2'd2, 4'b0000, 3'd0, 14'h0, '0, 1'b0, 3'd0, 0, 0, 2 + NSET, "clear");
    run(2'd2, 4'b0000, 3'd0, 14'h0, '0, 1'b0, 3'd0, 5, 2, 4 + NSET, "clear_drop");
    run(2'd3, 4'b0001, 3'd2, 14'h3, '1, 1'b1, 3'd3, 0, 0, 1, "illegal");
    run(2'd0, 4'b0110, 3'd1, 14'h55, '1, 1'b1, 3'd0, 0, 0, 3, "badway");
    run(2'd0, 4'b0000, 3'd6, 14'h77, '1, 1'b0, 3'd0, 0, 0, 3, "zeroway");

    // Abort a sweep mid-flight with reset while index 4 is being written.
    for (int w = 0; w < 200 && !bus.pl_ready; w++) step();
    bus.pl_cmd = 2'd2; bus.pl_valid = 1'b1; t = cyc; d0 = done_total;
    step();
    bus.pl_valid = 1'b0;
    for (int w = 0; w < 50 && cyc < t + 6; w++) step();
    chk("rst_mid.idx", {bus.vb_we, bus.arr_idx}, {1'b1, 3'd4});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid.strb", {bus.tag_we, bus.data_we, bus.vb_we, bus.lru_we, bus.done, bus.err}, '0);
    chk("rst_mid.req", bus.arb_req, 1'b0);
    chk("rst_mid.ready", bus.pl_ready, 1'b1);
    repeat (3) step();
    chk("rst_mid.nodone", done_total - d0, 0);
    dd = rnd_line();
    run(2'd0, 4'b1000, 3'd3, 14'h2BC, dd, 1'b0, 3'd0, 0, 0, 3, "post_rst");

    gnt_rand = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [1:0]      c;
      logic [WAYS-1:0] wy;
      c  = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 3));
      wy = ($urandom_range(0, 3) != 0) ? WAYS'(1 << $urandom_range(0, WAYS - 1)) : WAYS'($urandom);
      run(c, wy, IDX_W'($urandom), TAG_W'($urandom), rnd_line(), 1'($urandom), LRU_W'($urandom),
          0, 0, -1, "rand");
    end
    gnt_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cache_preload.md
Name: cache_preload

Overview:
- Backdoor writer for the 4-way L1 state arrays: tag RAMs, data SRAMs, valid bits, dirty bits and LRU register file.
- Accepts preload commands over a valid/ready interface and borrows the array write ports from the cache controller through a req/gnt handshake.
- Performs single-line installs, LRU writes and a full-index clear sweep, then pulses done.
- Used by benches and by boot-time init to place the cache in a known state.

Parameters:
WAYS, 4, number of ways (one-hot way select width)
IDX_W, 13, index width; sweep covers 2**IDX_W sets
TAG_W, 14, tag width
LINE_W, 256, data line width
LRU_W, 3, per-set LRU state width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pl_valid  in  1  command valid
pl_ready  out  1  command accepted when valid & ready
pl_cmd  in  2  0=WRITE_LINE, 1=SET_LRU, 2=CLEAR_ALL, 3=illegal
pl_way  in  WAYS  one-hot target way (WRITE_LINE)
pl_idx  in  IDX_W  target set
pl_tag  in  TAG_W  tag to install
pl_data  in  LINE_W  line data to install
pl_dirty  in  1  dirty bit to install
pl_lru  in  LRU_W  LRU value (SET_LRU)
arb_req  out  1  request for array write ports
arb_gnt  in  1  controller has quiesced and yielded ports
tag_we  out  WAYS  per-way tag RAM write enable
data_we  out  WAYS  per-way data SRAM write enable
arr_idx  out  IDX_W  index for all array writes
tag_d  out  TAG_W  tag write data
data_d  out  LINE_W  line write data
vb_we  out  1  valid/dirty bit write enable
vb_mask  out  WAYS  ways affected by vb_we
vb_val  out  1  valid value written to masked ways
mod_val  out  1  dirty value written to masked ways
lru_we  out  1  LRU write enable
lru_d  out  LRU_W  LRU write data
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done for illegal cmd

Behaviour:
- Reset: pl_ready=1, all other outputs 0, state IDLE, sweep counter 0. Reset mid-operation aborts; strobes low after that edge; no done.
- States: IDLE, REQ, WRITE, SWEEP, DONE.
- IDLE: pl_ready=1. On pl_valid&pl_ready, capture all pl_* fields; pl_ready=0 from next cycle until return to IDLE. cmd 3 goes directly to DONE with err=1, with no req and no writes; otherwise go to REQ.
- REQ: arb_req=1. It stays high through WRITE/SWEEP and drops in DONE. Wait for arb_gnt=1, then go to WRITE (cmd 0/1) or SWEEP (cmd 2) with counter=0.
- WRITE, cmd 0:
  - Single cycle with tag_we=pl_way, data_we=pl_way, vb_we=1, vb_mask=pl_way, vb_val=1, mod_val=pl_dirty.
  - arr_idx=pl_idx, tag_d=pl_tag, data_d=pl_data.
  - pl_way not one-hot (zero or multi-bit): no writes; err=1 with done.
- WRITE, cmd 1: single cycle with lru_we=1, lru_d=pl_lru, arr_idx=pl_idx.
- SWEEP:
  - Each granted cycle: vb_we=1, vb_mask=all ones, vb_val=0, mod_val=0, lru_we=1, lru_d=0, arr_idx=counter; counter increments.
  - After index 2**IDX_W-1 is written, go to DONE. The counter wraps to 0 and holds.
- arb_gnt low during WRITE/SWEEP: all strobes held 0 and the counter frozen; resume on the same index when gnt returns. A WRITE whose gnt drops repeats its write.
- DONE: one cycle, done=1, arb_req=0, then IDLE.
- Latency: accept at cycle T with gnt already high gives write at T+2 and done at T+3. CLEAR_ALL gives done at T+2+2**IDX_W.
- Write strobes are only ever high while arb_req=1 and arb_gnt=1. tag_d/data_d/lru_d are don't-care when their enable is low; the bench checks them as 0.

Test Plan:
- WRITE_LINE way=4'b0100 idx=5 tag=14'h1A3 data=256'h…DEAD dirty=1, gnt tied high -> one cycle with tag_we=data_we=vb_mask=4'b0100, vb_val=1, mod_val=1, arr_idx=5 at T+2; done at T+3; pl_ready low T+1..T+3.
- SET_LRU idx=7 lru=3'b101, gnt delayed 4 cycles -> arb_req high, no strobes for 4 cycles, then lru_we=1, lru_d=5, arr_idx=7 for exactly one cycle, then done.
- CLEAR_ALL with IDX_W=3 -> 8 consecutive cycles with arr_idx 0..7, vb_mask=4'hF, vb_val=0, lru_d=0; done at T+10.
- CLEAR_ALL with IDX_W=3, gnt dropped for 2 cycles at index 3 -> strobes low for 2 cycles, then resumes at index 3; done at T+12, with each index written exactly once.
- cmd=3, then WRITE_LINE with way=4'b0110 -> both produce done+err, with no arb_req for cmd 3 and zero write strobes for both.
- Reset asserted during a CLEAR_ALL sweep at index 4 -> the next cycle has all strobes 0, arb_req=0, pl_ready=1 and no done; a following WRITE_LINE completes normally.
